// File: rtl/regwr_arbiter.sv
// Two-requester register-file write arbiter with a registered write port and a saturating contention counter.
// Define REGWR_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester A has fixed priority.
module regwr_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              rf_stall,
   output logic              mux_sel,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [7:0]        conflict_cnt
);

   // Requester index; the encoding doubles as the destination-mux select.
   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_B = 1'b1
   } grant_e;

   logic              grant_a;
   logic              grant_b;
   logic              contended;

   logic              wr_en_q,   wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   grant_e            mux_sel_q, mux_sel_d;
   logic [7:0]        cnt_q,     cnt_d;

`ifdef REGWR_ROUND_ROBIN_EN
   grant_e            last_grant_q, last_grant_d;
`endif

   assign contended = a_valid && b_valid;

   // Grants are gated by rst_n so no handshake can complete while reset is held.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (rst_n && !rf_stall) begin
`ifdef REGWR_ROUND_ROBIN_EN
         if (contended) begin
            grant_a = (last_grant_q == GRANT_B);
            grant_b = (last_grant_q == GRANT_A);
         end else begin
            grant_a = a_valid;
            grant_b = b_valid;
         end
`else
         grant_a = a_valid;
         grant_b = b_valid && !a_valid;
`endif
      end
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      mux_sel_d = mux_sel_q;
      cnt_d     = cnt_q;
      // A transfer to register 0 still completes but never raises wr_en.
      if (grant_a) begin
         wr_en_d   = (a_addr != '0);
         wr_addr_d = a_addr;
         wr_data_d = a_data;
         mux_sel_d = GRANT_A;
      end else if (grant_b) begin
         wr_en_d   = (b_addr != '0);
         wr_addr_d = b_addr;
         wr_data_d = b_data;
         mux_sel_d = GRANT_B;
      end
      if (contended && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

`ifdef REGWR_ROUND_ROBIN_EN
   always_comb begin
      last_grant_d = last_grant_q;
      if (grant_a) begin
         last_grant_d = GRANT_A;
      end else if (grant_b) begin
         last_grant_d = GRANT_B;
      end
   end

   // Pointer resets to B so that A wins the first contention.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_q <= GRANT_B;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
      if (!rst_n) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         mux_sel_q <= GRANT_A;
         cnt_q     <= 8'd0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         mux_sel_q <= mux_sel_d;
         cnt_q     <= cnt_d;
      end
   end

   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign mux_sel      = mux_sel_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regwr_arbiter.sv
// Self-checking bench for regwr_arbiter: a cycle-level reference model checked on every falling edge,
// plus directed scenarios with literal expectations. Honours REGWR_ROUND_ROBIN_EN like the design.
module tb_regwr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_valid, b_valid, rf_stall;
   logic [4:0]  a_addr, b_addr;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready, mux_sel, wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [7:0]  conflict_cnt;

   int total = 0;
   int bad   = 0;

   regwr_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .rf_stall(rf_stall), .mux_sel(mux_sel),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who is granted (0 none, 1 A, 2 B) and what the write port must show.
   bit         started = 0;
   int         m_last  = 2;
   bit         m_wr_en;
   logic [4:0] m_wr_addr;
   logic [31:0] m_wr_data;
   bit         m_mux;
   int         m_cnt;

   function automatic int model_grant();
      if (!rst_n || rf_stall) return 0;
      if (a_valid && !b_valid) return 1;
      if (b_valid && !a_valid) return 2;
      if (a_valid && b_valid) begin
`ifdef REGWR_ROUND_ROBIN_EN
         return (m_last == 1) ? 2 : 1;
`else
         return 1;
`endif
      end
      return 0;
   endfunction

   always @(posedge clk) begin
      int g;
      g = model_grant();
      if (!rst_n) begin
         started   = 1;
         m_last    = 2;
         m_wr_en   = 0;
         m_wr_addr = 0;
         m_wr_data = 0;
         m_mux     = 0;
         m_cnt     = 0;
      end else begin
         m_wr_en = 0;
         if (g == 1) begin
            m_wr_en = (a_addr != 0); m_wr_addr = a_addr; m_wr_data = a_data; m_mux = 0; m_last = 1;
         end else if (g == 2) begin
            m_wr_en = (b_addr != 0); m_wr_addr = b_addr; m_wr_data = b_data; m_mux = 1; m_last = 2;
         end
         if (a_valid && b_valid && m_cnt < 255) m_cnt = m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      int g;
      if (started) begin
         g = model_grant();
         check("model a_ready", 64'(a_ready), 64'(g == 1));
         check("model b_ready", 64'(b_ready), 64'(g == 2));
         check("model wr_en", 64'(wr_en), 64'(m_wr_en));
         check("model wr_addr", 64'(wr_addr), 64'(m_wr_addr));
         check("model wr_data", 64'(wr_data), 64'(m_wr_data));
         check("model mux_sel", 64'(mux_sel), 64'(m_mux));
         check("model conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic set_in(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                         input logic st, input logic rn);
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      rf_stall = st; rst_n = rn;
   endtask

   task automatic do_reset();
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

`ifdef REGWR_ROUND_ROBIN_EN
   localparam logic [3:0] EXP_A = 4'b0101;
`else
   localparam logic [3:0] EXP_A = 4'b1111;
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      set_in(1, 5, 32'h1111_1111, 0, 0, 0, 0, 0);
      mid();
      check("a_ready in reset", 64'(a_ready), 64'(0));
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      mid();
      check("reset wr_en", 64'(wr_en), 64'(0));
      check("reset wr_addr", 64'(wr_addr), 64'(0));
      check("reset wr_data", 64'(wr_data), 64'(0));
      check("reset mux_sel", 64'(mux_sel), 64'(0));
      check("reset conflict_cnt", 64'(conflict_cnt), 64'(0));

      // Single requester A write
      tick();
      set_in(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
      mid();
      check("single a_ready", 64'(a_ready), 64'(1));
      check("single b_ready", 64'(b_ready), 64'(0));
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      mid();
      check("single wr_en", 64'(wr_en), 64'(1));
      check("single wr_addr", 64'(wr_addr), 64'(5));
      check("single wr_data", 64'(wr_data), 64'(32'hDEAD_BEEF));
      check("single mux_sel", 64'(mux_sel), 64'(0));
      tick();
      mid();
      check("idle wr_en", 64'(wr_en), 64'(0));
      check("idle hold wr_data", 64'(wr_data), 64'(32'hDEAD_BEEF));

      // Sustained contention for 4 cycles
      do_reset();
      tick();
      set_in(1, 1, 32'h11, 1, 2, 32'h22, 0, 1);
      for (int i = 0; i < 4; i++) begin
         mid();
         check("contend a_ready", 64'(a_ready), 64'(EXP_A[i]));
         check("contend b_ready", 64'(b_ready), 64'(!EXP_A[i]));
         if (i < 3) tick();
      end
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      mid();
      check("contend conflict_cnt", 64'(conflict_cnt), 64'(4));
      check("contend last mux_sel", 64'(mux_sel), 64'(!EXP_A[3]));

      // Register-0 write from B
      do_reset();
      tick();
      set_in(0, 0, 0, 1, 0, 32'h1234, 0, 1);
      mid();
      check("r0 b_ready", 64'(b_ready), 64'(1));
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      mid();
      check("r0 wr_en", 64'(wr_en), 64'(0));
      check("r0 mux_sel", 64'(mux_sel), 64'(1));
      check("r0 wr_data", 64'(wr_data), 64'(32'h1234));

      // Stall rising right after a grant: the registered write still shows
      do_reset();
      tick();
      set_in(1, 7, 32'h77, 0, 0, 0, 0, 1);
      tick();
      set_in(1, 8, 32'h88, 1, 9, 32'h99, 1, 1);
      mid();
      check("stall-edge wr_en", 64'(wr_en), 64'(1));
      check("stall-edge a_ready", 64'(a_ready), 64'(0));

      // Stall for 3 cycles, then release
      do_reset();
      tick();
      set_in(1, 3, 32'hA3, 1, 4, 32'hB4, 1, 1);
      for (int i = 0; i < 3; i++) begin
         mid();
         check("stall a_ready", 64'(a_ready), 64'(0));
         check("stall b_ready", 64'(b_ready), 64'(0));
         check("stall wr_en", 64'(wr_en), 64'(0));
         tick();
      end
      rf_stall = 0;
      mid();
      check("release a_ready", 64'(a_ready), 64'(1));
      tick();
      set_in(0, 0, 0, 1, 4, 32'hB4, 0, 1);
      mid();
      check("release b_ready", 64'(b_ready), 64'(1));
      check("release wr_addr A", 64'(wr_addr), 64'(3));
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      mid();
      check("release wr_en B", 64'(wr_en), 64'(1));
      check("release mux_sel B", 64'(mux_sel), 64'(1));

      // Saturation, then reset on a transfer cycle
      do_reset();
      tick();
      set_in(1, 6, 32'h66, 1, 10, 32'hAA, 0, 1);
      repeat (300) tick();
      mid();
      check("sat conflict_cnt", 64'(conflict_cnt), 64'(255));
      tick();
      rst_n = 0;
      mid();
      check("rst a_ready", 64'(a_ready), 64'(0));
      check("rst b_ready", 64'(b_ready), 64'(0));
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      mid();
      check("rst wr_en", 64'(wr_en), 64'(0));
      check("rst wr_addr", 64'(wr_addr), 64'(0));
      check("rst wr_data", 64'(wr_data), 64'(0));
      check("rst mux_sel", 64'(mux_sel), 64'(0));
      check("rst conflict_cnt", 64'(conflict_cnt), 64'(0));
      tick();
      mid();
      check("post-rst wr_en", 64'(wr_en), 64'(0));

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
